// File: rtl/clk_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : clk_tick_scheduler
// Description : Three-channel programmable clock-enable generator. Each
//               channel divides clk by its own divisor and emits a registered
//               single-cycle tick. Divisor writes pass through a one-cycle
//               LOAD state that realigns every channel to a common phase.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_tick_scheduler #(
    parameter int WIDTH    = 24,
    parameter int DIV0_RST = 2,
    parameter int DIV1_RST = 4,
    parameter int DIV2_RST = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             resync,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_sel,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [2:0]       tick,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_count_en;

    // A write is taken whenever the block is not busy in LOAD.
    assign cfg_ready = (r_state != ST_LOAD);
    assign running   = (r_state == ST_RUN);
    assign w_accept  = cfg_valid & cfg_ready;

    // Counting only proceeds in RUN when nothing of higher priority
    // (write, stop, resync) zeroes the channel counters this edge.
    assign w_count_en = (r_state == ST_RUN) & ~w_accept & run & ~resync;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: write acceptance outranks the run enable.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP: begin
                if (w_accept)   w_state_nxt = ST_LOAD;
                else if (run)   w_state_nxt = ST_RUN;
                else            w_state_nxt = ST_STOP;
            end
            ST_RUN: begin
                if (w_accept)   w_state_nxt = ST_LOAD;
                else if (!run)  w_state_nxt = ST_STOP;
                else            w_state_nxt = ST_RUN;
            end
            ST_LOAD: begin
                w_state_nxt = run ? ST_RUN : ST_STOP;
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            localparam logic [WIDTH-1:0] c_div_rst =
                (gi == 0) ? WIDTH'(DIV0_RST) :
                (gi == 1) ? WIDTH'(DIV1_RST) : WIDTH'(DIV2_RST);

            logic [WIDTH-1:0] r_div;
            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] w_last;
            logic             r_tick;

            // Terminal count is d-1; divisors 0 and 1 both collapse to d=1,
            // so no subtraction ever wraps and the all-ones divisor is safe.
            assign w_last = (r_div <= WIDTH'(1)) ? '0 : (r_div - WIDTH'(1));

            // Divisor register; only an accepted write addressing this
            // channel changes it (select 3 addresses no channel).
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_div <= c_div_rst;
                end else if (w_accept && (cfg_sel == 2'(gi))) begin
                    r_div <= cfg_div;
                end
            end

            // Period counter and registered tick pulse.
            always_ff @(posedge clk) begin
                if (reset || !w_count_en) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else if (r_cnt == w_last) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_tick <= 1'b0;
                end
            end

            assign tick[gi] = r_tick;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/clk_tick_scheduler.md
CLK_TICK_SCHEDULER -- requirements
Module: clk_tick_scheduler

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set the bit width of every divisor register and counter.
REQ-002 Parameter DIV0_RST, default 2, SHALL set the channel-0 divisor after reset.
REQ-003 Parameter DIV1_RST, default 4, SHALL set the channel-1 divisor after reset.
REQ-004 Parameter DIV2_RST, default 100000, SHALL set the channel-2 divisor after reset.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 run  input  1  SHALL be the global enable: 1 = ticks generated, 0 = all ticks stopped.
REQ-008 resync  input  1  SHALL request zeroing of all channel counters (phase realign).
REQ-009 cfg_valid  input  1  SHALL qualify a divisor write request.
REQ-010 cfg_sel  input  2  SHALL select the target channel (0-2); value 3 SHALL mean "no divisor write, realign only".
REQ-011 cfg_div  input  WIDTH  SHALL be the new divisor value.
REQ-012 cfg_ready  output  1  SHALL indicate a write can be accepted this cycle.
REQ-013 tick  output  3  SHALL carry one single-cycle clock-enable pulse per channel, registered.
REQ-014 running  output  1  SHALL be 1 exactly when the FSM is in RUN.

Function
REQ-015 FSM states SHALL be STOP, RUN and LOAD; each channel i SHALL hold div[i] and cnt[i].
REQ-016 Effective divisor d[i] SHALL be div[i], except div[i] of 0 or 1 SHALL act as 1.
REQ-017 STOP SHALL hold all cnt at 0 and tick at 0, with cfg_ready=1.
REQ-018 STOP, with run=1 and no accepted write, SHALL go to RUN at the next edge with all cnt=0.
REQ-019 In RUN, at each edge, per channel: if cnt[i]==d[i]-1 then cnt[i]<=0 and tick[i]<=1, else cnt[i]<=cnt[i]+1 and tick[i]<=0.
REQ-020 Timing: RUN entered at edge k SHALL give tick[i] high after edges k+d, k+2d, ..., each pulse exactly one cycle wide (d=1: high every cycle from k+1).
REQ-021 RUN with run=0 SHALL go to STOP at the next edge, zeroing cnt and tick.
REQ-022 A write SHALL be accepted at an edge where cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in STOP and RUN and 0 in LOAD.
REQ-023 On acceptance, the block SHALL load div[cfg_sel]<=cfg_div (none for cfg_sel=3), go to LOAD, and zero all cnt and tick.
REQ-024 LOAD SHALL last exactly one cycle with tick=0, then go to RUN if run=1, else STOP, with cnt=0 (RUN timing per REQ-020).
REQ-025 In RUN, resync=1 with no accepted write SHALL zero all cnt and tick at that edge and remain in RUN; in STOP, resync SHALL have no effect.
REQ-026 Priority SHALL be reset > write acceptance > run=0 > resync > normal counting.
REQ-027 A divisor change SHALL never affect a channel without passing through LOAD, so all channels are phase-aligned after every write.
REQ-028 Counter comparisons SHALL be WIDTH-bit unsigned; d=2^WIDTH-1 SHALL be supported with no overflow.

Reset
REQ-029 reset=1 SHALL force state=STOP, cnt=0, tick=3'b000, running=0, cfg_ready=1 and div[0..2]=DIV0_RST/DIV1_RST/DIV2_RST at the next edge, overriding any concurrent write, run or resync.
REQ-030 reset asserted mid-RUN or in LOAD SHALL discard the in-progress write and period, with no tick in the cycle after the reset edge.

Verification
REQ-031 Reset, then run=1 at edge k -> tick[0] high after edges k+2, k+4, ...; tick[1] after k+4, k+8, ...; running=1 from k.
REQ-032 In RUN, write sel=1 div=3 -> cfg_ready=0 and tick=0 for one cycle; all channels restart; tick[1] every 3 cycles; tick[0] still every 2 cycles.
REQ-033 Write sel=0 div=0, then div=1 -> tick[0] high every cycle from the first RUN edge.
REQ-034 run=0 and cfg_valid=1 (sel=2, div=5) at the same edge -> LOAD, then STOP; no ticks; later run=1 -> tick[2] every 5 cycles.
REQ-035 resync pulse in RUN at cnt[1]=2 (d=4) -> tick=0 that cycle; next tick[1] exactly 4 edges later; sel=3 write -> same realignment, divisors unchanged.
REQ-036 reset during LOAD with cfg_valid held high -> STOP, divisors equal the reset values, cfg_ready=1.
